// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// UART_TX_PARITY_EN adds the PARITY state to the transmit FSM (8E1 frames).
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_e;

    function automatic logic uart_even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers wrap naturally and count tells full from empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_core.sv
// Baud-timed UART transmitter fed from a byte FIFO; 8N1, or 8E1 when
// UART_TX_PARITY_EN is defined.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_busy,
    output logic [CW-1:0] fifo_count,
    output logic          uart_tx
);

    localparam int             DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0]     BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_tx_state_e state;
    logic [DW-1:0]  div_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic [7:0]     head;
    logic           full, empty;
    logic           bit_end, pop;
`ifdef UART_TX_PARITY_EN
    logic           parity;
`endif

    assign bit_end  = (div_cnt == DIV_LAST);
    // Popping on the last STOP cycle chains frames with no idle gap.
    assign pop      = !empty && (state == ST_IDLE || (state == ST_STOP && bit_end));
    assign tx_ready = !full;
    assign tx_busy  = (state != ST_IDLE) || !empty;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (tx_valid),
        .pop    (pop),
        .wdata  (tx_data),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    // uart_tx is loaded with the level of the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            if (state != ST_IDLE) div_cnt <= bit_end ? '0 : div_cnt + DW'(1);
            if (pop) begin
                state   <= ST_START;
                div_cnt <= '0;
                shift   <= head;
                uart_tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity  <= uart_even_parity(head);
`endif
            end else if (bit_end) begin
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        uart_tx <= shift[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state   <= ST_PARITY;
                            uart_tx <= parity;
`else
                            state   <= ST_STOP;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        state   <= ST_STOP;
                        uart_tx <= 1'b1;
                    end
`endif
                    default: begin
                        state   <= ST_IDLE;
                        uart_tx <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: two instances (CLK_DIV=4 and the minimum 2)
// with a line monitor that checks every sampled cycle of each frame.
module tb_uart_tx_core;

    localparam int DIV_A = 4;
    localparam int DIV_B = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    data  [2];
    logic          valid [2];
    logic          ready [2];
    logic          busy  [2];
    logic          line  [2];
    logic [CW-1:0] cnt   [2];

    int checks = 0;
    int failures = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int gap    [2];
    int frames [2];

    always #5 clk = ~clk;

    uart_tx_core #(.CLK_DIV(DIV_A), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .resetn(resetn), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]), .uart_tx(line[0]));

    uart_tx_core #(.CLK_DIV(DIV_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .resetn(resetn), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]), .uart_tx(line[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected serial frame, bit 0 first on the wire.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b01, b, 1'b0};
`endif
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Called at a negedge; holds valid until the byte is taken.
    task automatic send(input int d, input logic [7:0] b);
        logic acc = 1'b0;
        int   t = 0;
        data[d]  = b;
        valid[d] = 1'b1;
        while (!acc && t < 2000) begin
            acc = ready[d];
            @(posedge clk);
            if (acc) begin
                if (d == 0) q0.push_back(b); else q1.push_back(b);
            end
            @(negedge clk);
            t++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int t = 0;
        while ((busy[d] !== 1'b0 || qsize(d) != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("drain_dut%0d", d), 32'(t < 5000), 1);
    endtask

    task automatic monitor(input int d, input int div);
        int idle = 0;
        forever begin
            @(negedge clk);
            if (!resetn || line[d] === 1'b1) begin
                idle = resetn ? idle + 1 : 0;
            end else if (qsize(d) == 0) begin
                chk($sformatf("unexpected_frame_dut%0d", d), 1, 0);
                repeat (NBITS * div) @(negedge clk);
                idle = 0;
            end else begin
                logic [7:0]  b;
                logic [10:0] f;
                logic        aborted = 1'b0;
                b = (d == 0) ? q0.pop_front() : q1.pop_front();
                f = frame_of(b);
                gap[d] = idle;
                frames[d]++;
                for (int i = 0; i < NBITS && !aborted; i++) begin
                    logic ok = 1'b1;
                    for (int c = 0; c < div && !aborted; c++) begin
                        if (i > 0 || c > 0) @(negedge clk);
                        if (!resetn) aborted = 1'b1;
                        else if (line[d] !== f[i]) ok = 1'b0;
                    end
                    if (!aborted)
                        chk($sformatf("dut%0d byte %02h bit%0d", d, b, i), 32'(ok), 1);
                end
                idle = 0;
            end
        end
    endtask

    initial monitor(0, DIV_A);
    initial monitor(1, DIV_B);

    initial begin
        int f0;
        int t;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0;
            data[d]  = '0;
            gap[d]    = 0;
            frames[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_line_dut%0d", d),  32'(line[d]),  1);
            chk($sformatf("reset_ready_dut%0d", d), 32'(ready[d]), 1);
            chk($sformatf("reset_busy_dut%0d", d),  32'(busy[d]),  0);
            chk($sformatf("reset_count_dut%0d", d), 32'(cnt[d]),   0);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: latency, count and busy timing.
        send(0, 8'hA5);
        chk("single_count_after_push", 32'(cnt[0]), 1);
        chk("single_line_before_pop", 32'(line[0]), 1);
        chk("single_busy_after_push", 32'(busy[0]), 1);
        @(negedge clk);
        chk("single_count_after_pop", 32'(cnt[0]), 0);
        chk("single_line_after_pop", 32'(line[0]), 0);
        repeat (NBITS * DIV_A - 1) @(negedge clk);
        chk("single_busy_last_stop", 32'(busy[0]), 1);
        @(negedge clk);
        chk("single_busy_done", 32'(busy[0]), 0);
        chk("single_frames", 32'(frames[0]), 1);

        // Back-to-back frames with no gap.
        f0 = frames[0];
        send(0, 8'h00);
        send(0, 8'hFF);
        t = 0;
        while (frames[0] < f0 + 2 && t < 1000) begin @(negedge clk); t++; end
        chk("b2b_second_frame_seen", 32'(frames[0]), 32'(f0 + 2));
        chk("b2b_gap", 32'(gap[0]), 0);
        drain(0);

        // Fill to full, then one more byte waits for the first frame to end.
        for (int i = 1; i <= 5; i++) send(0, 8'(i));
        chk("full_count", 32'(cnt[0]), 4);
        chk("full_ready", 32'(ready[0]), 0);
        send(0, 8'h06);
        drain(0);

        // Parity reference bytes and the minimum divider.
        send(0, 8'h07);
        send(0, 8'h03);
        send(1, 8'h5A);
        drain(0);
        drain(1);

        // Randomized traffic on both instances.
        fork
            for (int i = 0; i < 24; i++) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                send(0, 8'($urandom));
            end
            for (int i = 0; i < 24; i++) begin
                repeat ($urandom_range(0, 15)) @(negedge clk);
                send(1, 8'($urandom));
            end
        join
        drain(0);
        drain(1);

        // Reset during DATA bit 3 with two bytes queued.
        f0 = frames[0];
        send(0, 8'hC3);
        send(0, 8'h3C);
        send(0, 8'h99);
        t = 0;
        while (frames[0] == f0 && t < 100) begin @(negedge clk); t++; end
        repeat (4 * DIV_A + 1) @(negedge clk);
        chk("rst_queued_count", 32'(cnt[0]), 2);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_line", 32'(line[0]), 1);
        chk("rst_async_count", 32'(cnt[0]), 0);
        chk("rst_async_busy", 32'(busy[0]), 0);
        chk("rst_async_ready", 32'(ready[0]), 1);
        q0.delete();
        q1.delete();
        f0 = frames[0];
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (15 * DIV_A) @(negedge clk);
        chk("rst_no_residual_frame", 32'(frames[0]), 32'(f0));
        chk("rst_line_idle", 32'(line[0]), 1);
        chk("rst_busy_idle", 32'(busy[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
